// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver sampling Rx mid-bit on a 16x oversampling enable, with ready/ready_clr handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (sets parity_err on mismatch).
module uart_rx_oversample #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 Rx,
    input  logic                 clken,
    input  logic                 ready_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [SAMP_W-1:0]      samp_q, samp_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   fe_q, fe_d;
    logic                   ov_q, ov_d;
    logic                   pe_q, pe_d;
    logic                   rx_meta_q, rx_s_q;
    logic                   rx_s;

    assign rx_s       = rx_s_q;
    assign data_out   = data_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;
    assign parity_err = pe_q;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            pe_q    <= pe_d;
        end
    end

    // Handshake clears are applied first so that a same-cycle set from the FSM wins.
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = ready_q & ~ready_clr;
        fe_d    = fe_q & ~ready_clr;
        ov_d    = ov_q & ~ready_clr;
        pe_d    = pe_q & ~ready_clr;

        if (clken) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        samp_d  = '0;
                    end
                end
                S_START: begin
                    if (samp_q == SAMP_MID) begin
                        samp_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
                S_DATA: begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d         = '0;
                        shift_d[bit_q] = rx_s;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
                S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (samp_q == SAMP_LAST) begin
                        samp_d  = '0;
                        state_d = S_STOP;
                        if (rx_s != (^shift_q)) begin
                            pe_d = 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
`else
                    state_d = S_IDLE;
`endif
                end
                S_STOP: begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d  = '0;
                        state_d = S_IDLE;
                        if (rx_s) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            if (ready_q) begin
                                ov_d = 1'b1;
                            end
                        end else begin
                            fe_d = 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx_oversample;

    logic       clk_50m = 1'b0;
    logic       rst = 1'b1;
    logic       Rx = 1'b1;
    logic       clken = 1'b0;
    logic       ready_clr = 1'b0;
    logic [7:0] data_out;
    logic       ready, busy, frame_err, overrun, parity_err;

    int total = 0;
    int bad = 0;
    int cdiv = 27;
    int ccnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       fe;
        logic       ov;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    logic [7:0] m_data;
    logic       m_rdy, m_fe, m_ov, m_pe;

    uart_rx_oversample #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .Rx        (Rx),
        .clken     (clken),
        .ready_clr (ready_clr),
        .data_out  (data_out),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #10 clk_50m = ~clk_50m;

    // Baud-generator stand-in: one clken pulse every cdiv clocks.
    always @(posedge clk_50m) begin
        #1;
        if (ccnt >= cdiv - 1) begin
            ccnt  = 0;
            clken = 1'b1;
        end else begin
            ccnt  = ccnt + 1;
            clken = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_fe   = 1'b0;
        m_ov   = 1'b0;
        m_pe   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        cycles(n);
    endtask

    task automatic line_bit(input logic b);
        Rx = b;
        cycles(16 * cdiv);
    endtask

    task automatic clr();
        ready_clr = 1'b1;
        cycles(1);
        ready_clr = 1'b0;
        m_rdy = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
        m_pe  = 1'b0;
    endtask

    // Model a whole frame at once, queue the expected outcome, then put the bits on the line.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        exp_t x;
`ifdef UART_RX_PARITY_EN
        if (par_b != (^d)) m_pe = 1'b1;
`endif
        if (stop_b) begin
            if (m_rdy) m_ov = 1'b1;
            m_rdy  = 1'b1;
            m_data = d;
        end else begin
            m_fe = 1'b1;
        end
        x.data = m_data;
        x.rdy  = m_rdy;
        x.fe   = m_fe;
        x.ov   = m_ov;
        x.pe   = m_pe;
        exp_q.push_back(x);

        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        line_bit(par_b);
`endif
        line_bit(stop_b);
        Rx = 1'b1;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_data_out"},   32'(data_out),   32'(m_data));
        chk({tag, "_ready"},      32'(ready),      32'(m_rdy));
        chk({tag, "_frame_err"},  32'(frame_err),  32'(m_fe));
        chk({tag, "_overrun"},    32'(overrun),    32'(m_ov));
        chk({tag, "_parity_err"}, 32'(parity_err), 32'(m_pe));
        chk({tag, "_busy"},       32'(busy),       32'(0));
    endtask

    // Monitor: a result is presented when ready, overrun or frame_err rises.
    logic p_rdy = 1'b0, p_fe = 1'b0, p_ov = 1'b0, p_clken = 1'b0;
    always @(negedge clk_50m) begin
        if (!rst && ((ready && !p_rdy) || (overrun && !p_ov) || (frame_err && !p_fe))) begin
            if (exp_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL unexpected_event: data_out=%0h ready=%0b frame_err=%0b overrun=%0b, none expected",
                         data_out, ready, frame_err, overrun);
            end else begin
                e = exp_q.pop_front();
                chk("ev_data_out",   32'(data_out),   32'(e.data));
                chk("ev_ready",      32'(ready),      32'(e.rdy));
                chk("ev_frame_err",  32'(frame_err),  32'(e.fe));
                chk("ev_overrun",    32'(overrun),    32'(e.ov));
                chk("ev_parity_err", 32'(parity_err), 32'(e.pe));
                chk("ev_busy",       32'(busy),       32'(0));
                chk("ev_latency_after_clken", 32'(p_clken), 32'(1));
            end
        end
        p_rdy   = ready;
        p_fe    = frame_err;
        p_ov    = overrun;
        p_clken = clken;
    end

    initial begin
        #50000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       sb, pb;

        model_reset();
        rst = 1'b1;
        cycles(5);
        chk_outputs("reset");
        rst = 1'b0;
        idle(60);
        chk_outputs("post_reset");

        // Clean frame 0x55
        send_frame(8'h55, 1'b1, ^8'h55);
        idle(100);
        chk_outputs("f55");
        clr();
        chk_outputs("f55_clr");

        // Short low glitch: start aborts silently
        Rx = 1'b0;
        cycles(4 * cdiv);
        idle(20 * cdiv);
        chk_outputs("glitch");

        // Bad stop bit
        send_frame(8'hA3, 1'b0, ^8'hA3);
        idle(100);
        chk_outputs("ferr");
        clr();
        chk_outputs("ferr_clr");

        // Back-to-back frames without acknowledge -> overrun
        send_frame(8'h12, 1'b1, ^8'h12);
        send_frame(8'h34, 1'b1, ^8'h34);
        idle(100);
        chk_outputs("overrun");
        clr();
        chk_outputs("overrun_clr");

        // Reset during data bit 3; the partial frame must vanish
        send_frame(8'h9C, 1'b1, ^8'h9C);
        idle(100);
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        line_bit(1'b1);
        Rx = 1'b0;
        cycles(8 * cdiv);
        rst = 1'b1;
        cycles(3);
        model_reset();
        chk_outputs("in_reset");
        Rx = 1'b1;
        cycles(5);
        rst = 1'b0;
        idle(30 * cdiv);
        chk_outputs("after_reset");
        send_frame(8'hC7, 1'b1, ^8'hC7);
        idle(100);
        chk_outputs("fc7");
        clr();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle(100);
        chk_outputs("par_bad");
        clr();
        chk_outputs("par_bad_clr");
        send_frame(8'h07, 1'b1, 1'b1);
        idle(100);
        chk_outputs("par_good");
        clr();
`endif

        // Randomized frames at a faster baud
        cdiv = 3;
        idle(60);
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            send_frame(d, sb, pb);
            idle(30 + int'($urandom_range(0, 40)));
            chk_outputs("rand");
            clr();
        end

        idle(300);
        chk("all_events_seen", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- UART receiver; the downstream consumer of the serial line driven by the team's transmitter (8N1, LSB first, idle-high).
- Samples the asynchronous Rx line using a 16x-oversampling clock enable from the shared baud generator.
- Reassembles bytes and presents them with a ready / ready_clr handshake, plus framing and overrun status for the host logic.

Parameters:
- OVERSAMPLE, 16, clken ticks per bit; power of two, minimum 8.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk_50m  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- Rx  input  1  asynchronous serial line, idle 1.
- clken  input  1  single-cycle enable pulse, OVERSAMPLE times per bit period.
- ready_clr  input  1  host acknowledge; clears ready, frame_err and overrun.
- data_out  output  DATA_BITS  last correctly framed byte.
- ready  output  1  data_out holds an unacknowledged byte.
- busy  output  1  frame reception in progress (state != IDLE).
- frame_err  output  1  sticky; a stop bit was sampled as 0.
- overrun  output  1  sticky; a byte completed while ready was already 1.
- parity_err  output  1  sticky; parity mismatch (see Optional Feature).

Behaviour:
- Reset values: data_out 0, ready 0, busy 0, frame_err 0, overrun 0, parity_err 0, state IDLE.
- Reset also sets both synchronizer flops to 1. Reset is honoured mid-frame; the partial frame is discarded.
- Rx passes through a 2-flop synchronizer (rx_s). rx_s is the only version of Rx used anywhere.
- Internal counters:
  - sample counter, log2(OVERSAMPLE) bits.
  - bit index, 3 bits.
  - shift register, DATA_BITS wide.
- Counters advance only on clken cycles; there is no other state change except handshake clearing.
- IDLE:
  - On clken with rx_s==0: go to START, sample=0.
- START:
  - On clken: sample++.
  - When sample reaches OVERSAMPLE/2-1 with rx_s==0: go to DATA, sample=0, bit=0.
  - When sample reaches OVERSAMPLE/2-1 with rx_s==1: treat as a glitch, return to IDLE with no flags changed.
- DATA:
  - On clken: sample++.
  - When sample==OVERSAMPLE-1: shift[bit]<=rx_s, sample=0 (the sample lands mid-bit).
  - After bit==DATA_BITS-1: go to STOP (or PARITY if enabled); otherwise bit++.
- STOP:
  - On clken: sample++.
  - When sample==OVERSAMPLE-1 and rx_s==1: data_out<=shift, ready<=1, and overrun<=1 if ready was already 1.
  - When sample==OVERSAMPLE-1 and rx_s==0: frame_err<=1; data_out and ready are unchanged.
  - Either way, return to IDLE.
  - IDLE is re-entered at mid-stop-bit, so back-to-back frames are accepted.
- Latency: ready rises on the clk_50m edge following the clken that samples the stop bit.
- Handshake:
  - ready_clr high for one or more cycles clears ready, frame_err, overrun and parity_err.
  - If a set and ready_clr occur in the same cycle, the set wins.
- On overrun, data_out is overwritten with the newer byte.
- A line held low indefinitely produces repeated frame_err frames; there is no lockup.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at the same OVERSAMPLE-1 point.
  - Expects even parity over the data bits.
  - A mismatch sets parity_err. The byte is still delivered if the stop bit is good.
- Undefined:
  - No PARITY state; the frame is 8N1.
  - parity_err is tied to 0.

Test Plan:
- clken every 27 cycles; Rx drives frame 0x55 (bit period 432 cycles) -> data_out=0x55, ready=1 one cycle after the stop-bit sample, busy=0 afterwards, frame_err=0.
- Rx low pulse of 4 clken ticks from idle -> START aborts, busy returns to 0; ready, frame_err and data_out unchanged.
- Frame 0xA3 with stop bit forced 0 -> frame_err=1, ready=0, data_out keeps its prior value. Then ready_clr -> frame_err=0.
- Frames 0x12 then 0x34 with no ready_clr -> data_out=0x34, ready=1, overrun=1. Pulse ready_clr -> ready=0, overrun=0.
- Assert rst during data bit 3 of a frame, release, then send 0xC7 -> only 0xC7 is delivered; all outputs were at reset values during rst.
- UART_RX_PARITY_EN defined: frame 0x07 with parity bit 0 -> parity_err=1, data_out=0x07. Repeat with parity bit 1 -> parity_err stays 0 after ready_clr.
